// File: rtl/adder_pkg.sv
// Shared definitions for the sequential adder/subtractor family:
// FSM state type, default geometry and counter sizing.
package adder_pkg;

    localparam int unsigned DefaultWidth = 32;
    localparam int unsigned DefaultChunk = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // A single-slice configuration still needs a one-bit counter.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cla_sub_chunk.sv
// Combinational CHUNK-bit borrow-lookahead subtract slice: d = a - b - bin.
// Borrow generate = ~a & b, borrow propagate = a XNOR b.
module cla_sub_chunk #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             bin,
    output logic [CHUNK-1:0] d,
    output logic             bout
);

    logic [CHUNK-1:0] w_g;
    logic [CHUNK-1:0] w_p;
    logic [CHUNK:0]   w_chain;

    assign w_g = ~a & b;
    assign w_p = ~(a ^ b);

    always_comb begin
        w_chain    = '0;
        w_chain[0] = bin;
        for (int i = 0; i < CHUNK; i++) begin
            w_chain[i+1] = w_g[i] | (w_p[i] & w_chain[i]);
        end
    end

    assign d    = a ^ b ^ w_chain[CHUNK-1:0];
    assign bout = w_chain[CHUNK];

endmodule

// File: rtl/cla_seq_subtractor.sv
// Multi-cycle subtractor: one CHUNK-bit borrow-lookahead slice per cycle, LSB first,
// with the inter-slice borrow registered and valid/ready handshakes on both sides.
import adder_pkg::*;

module cla_seq_subtractor #(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned CHUNK = DefaultChunk
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Zero,
    output logic             Ovf
);

    localparam int unsigned NumSlices = WIDTH / CHUNK;
    localparam int unsigned CntW      = cnt_width(NumSlices);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CntW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic [WIDTH-1:0] r_diff_out;
    logic             r_bout_out;
    logic             r_zero_out;
    logic             r_ovf_out;

    logic [CHUNK-1:0] w_a_slice;
    logic [CHUNK-1:0] w_b_slice;
    logic [CHUNK-1:0] w_d_slice;
    logic             w_slice_bout;
    logic [WIDTH-1:0] w_diff_nxt;
    logic             w_last;
    logic             w_accept;
    logic             w_ovf_nxt;

    assign w_accept = (r_state == StIdle) && in_valid;
    assign w_last   = (r_cnt == CntW'(NumSlices - 1));

    always_comb begin
        w_a_slice = '0;
        w_b_slice = '0;
        for (int k = 0; k < NumSlices; k++) begin
            if (r_cnt == CntW'(k)) begin
                w_a_slice = r_a[k*CHUNK +: CHUNK];
                w_b_slice = r_b[k*CHUNK +: CHUNK];
            end
        end
    end

    cla_sub_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a    (w_a_slice),
        .b    (w_b_slice),
        .bin  (r_borrow),
        .d    (w_d_slice),
        .bout (w_slice_bout)
    );

    // Working diff with the current slice merged in; on the last slice this is the result.
    always_comb begin
        w_diff_nxt = r_diff;
        for (int k = 0; k < NumSlices; k++) begin
            if (r_cnt == CntW'(k)) begin
                w_diff_nxt[k*CHUNK +: CHUNK] = w_d_slice;
            end
        end
    end

    assign w_ovf_nxt = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff_nxt[WIDTH-1] != r_a[WIDTH-1]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (in_valid) w_state_nxt = StRun;
            StRun:   if (w_last) w_state_nxt = StDone;
            StDone:  if (out_ready) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == StIdle);
        out_valid = (r_state == StDone);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_a      <= A;
            r_b      <= B;
            r_diff   <= '0;
            r_borrow <= Bin;
        end else if (r_state == StRun) begin
            r_diff   <= w_diff_nxt;
            r_borrow <= w_slice_bout;
            r_cnt    <= w_last ? '0 : r_cnt + CntW'(1);
        end
    end

    // Result registers only move on the RUN->DONE edge and hold until the next result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_diff_out <= '0;
            r_bout_out <= 1'b0;
            r_zero_out <= 1'b0;
            r_ovf_out  <= 1'b0;
        end else if ((r_state == StRun) && w_last) begin
            r_diff_out <= w_diff_nxt;
            r_bout_out <= w_slice_bout;
            r_zero_out <= (w_diff_nxt == '0);
            r_ovf_out  <= w_ovf_nxt;
        end
    end

    assign Diff = r_diff_out;
    assign Bout = r_bout_out;
    assign Zero = r_zero_out;
    assign Ovf  = r_ovf_out;

endmodule
